// File: rtl/fir_sample_loader.sv
// Streams 8-bit samples from a valid/ready source into the shared FIR sample memory, then kicks fir_top.
// Optional running sample checksum output enabled by defining FIR_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for cfg_go; illegal counts raise cfg_err
// LOAD     | s_ready high, each handshake is written to memory next cycle
// KICK     | last write in flight; fir_start is raised on the way out
// WAIT_FIR | waiting for fir_done from fir_top
// DONE     | job_done pulse, then back to IDLE
module fir_sample_loader #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 8,
   parameter int MAX_SAMPLES = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_go,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W-1:0] cfg_count,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              fir_start,
   input  logic              fir_done,
   output logic              busy,
   output logic              job_done,
   output logic              cfg_err,
   output logic [ADDR_W-1:0] loaded_count
`ifdef FIR_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_KICK,
      ST_WAIT_FIR,
      ST_DONE
   } state_t;

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_SAMPLES);

   state_t              state;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   count_q;

   logic                cfg_legal;
   logic                handshake;
   logic [ADDR_W-1:0]   next_count;
   logic [ADDR_W-1:0]   wr_addr;
   logic                last_sample;

   assign cfg_legal   = (cfg_count != '0) && ({1'b0, cfg_count} <= MAX_CNT);
   assign handshake   = s_valid && s_ready;
   assign next_count  = loaded_count + ADDR_W'(1);
   // Natural ADDR_W-bit overflow gives the silent wrap past the top of memory.
   assign wr_addr     = base_q + loaded_count;
   assign last_sample = (next_count == count_q);

`ifdef FIR_LOADER_CHECKSUM_EN
   logic [15:0] sample_ext;
   assign sample_ext = {{(16-DATA_W){s_data[DATA_W-1]}}, s_data};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         base_q       <= '0;
         count_q      <= '0;
         s_ready      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         fir_start    <= 1'b0;
         busy         <= 1'b0;
         job_done     <= 1'b0;
         cfg_err      <= 1'b0;
         loaded_count <= '0;
`ifdef FIR_LOADER_CHECKSUM_EN
         checksum     <= '0;
`endif
      end else begin
         mem_we    <= 1'b0;
         fir_start <= 1'b0;
         job_done  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (cfg_go) begin
                  if (cfg_legal) begin
                     cfg_err      <= 1'b0;
                     loaded_count <= '0;
                     base_q       <= cfg_base_addr;
                     count_q      <= cfg_count;
                     s_ready      <= 1'b1;
                     busy         <= 1'b1;
                     state        <= ST_LOAD;
`ifdef FIR_LOADER_CHECKSUM_EN
                     checksum     <= '0;
`endif
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (handshake) begin
                  mem_we       <= 1'b1;
                  mem_addr     <= wr_addr;
                  mem_wdata    <= s_data;
                  loaded_count <= next_count;
`ifdef FIR_LOADER_CHECKSUM_EN
                  checksum     <= checksum + sample_ext;
`endif
                  if (last_sample) begin
                     s_ready <= 1'b0;
                     state   <= ST_KICK;
                  end
               end
            end

            // The final write is on the bus during KICK, so the start pulse lands one cycle later.
            ST_KICK: begin
               fir_start <= 1'b1;
               state     <= ST_WAIT_FIR;
            end

            ST_WAIT_FIR: begin
               if (fir_done) begin
                  job_done <= 1'b1;
                  state    <= ST_DONE;
               end
            end

            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               s_ready <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_sample_loader.sv
// Directed bench for fir_sample_loader: step stream, stalled stream, address wrap, config errors, mid-job reset.
// Define FIR_LOADER_CHECKSUM_EN to also exercise the checksum port.
module tb_fir_sample_loader;

   logic       clk;
   logic       rst;
   logic       cfg_go;
   logic [9:0] cfg_base_addr;
   logic [9:0] cfg_count;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       mem_we;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       fir_start;
   logic       fir_done;
   logic       busy;
   logic       job_done;
   logic       cfg_err;
   logic [9:0] loaded_count;
`ifdef FIR_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int vectors;
   int miscompares;

   logic [7:0] pat [0:63];

   // write log captured on the falling edge
   int         nwr;
   int         cyc;
   int         wr_cyc  [0:63];
   logic [9:0] wr_addr [0:63];
   logic [7:0] wr_data [0:63];
   int         fs_cnt;
   int         overlap;

   fir_sample_loader dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_go        (cfg_go),
      .cfg_base_addr (cfg_base_addr),
      .cfg_count     (cfg_count),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_ready       (s_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .fir_start     (fir_start),
      .fir_done      (fir_done),
      .busy          (busy),
      .job_done      (job_done),
      .cfg_err       (cfg_err),
      .loaded_count  (loaded_count)
`ifdef FIR_LOADER_CHECKSUM_EN
      ,
      .checksum      (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_we) begin
         if (nwr < 64) begin
            wr_cyc[nwr]  = cyc;
            wr_addr[nwr] = mem_addr;
            wr_data[nwr] = mem_wdata;
         end
         nwr = nwr + 1;
      end
      if (fir_start) fs_cnt = fs_cnt + 1;
      if (fir_start && mem_we) overlap = overlap + 1;
   end

   task automatic run_job(input logic [9:0] base, input logic [9:0] cnt, input bit toggle, input string tag);
      int idx;
      int k;
      bit hs;
      logic [9:0] exp_addr;
      nwr = 0; fs_cnt = 0; overlap = 0;
      @(negedge clk);
      cfg_go = 1'b1; cfg_base_addr = base; cfg_count = cnt;
      @(negedge clk);
      cfg_go = 1'b0;
      vectors++;
      if (busy !== 1'b1 || s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s start: busy=%b s_ready=%b, required 1/1", tag, busy, s_ready);
      end
      idx = 0; k = 0;
      while (idx < int'(cnt) && k < 400) begin
         s_valid = toggle ? (k % 2 == 0) : 1'b1;
         s_data  = pat[idx];
         hs = s_valid && s_ready;
         @(negedge clk);
         if (hs) idx++;
         k++;
      end
      s_valid = 1'b0;
      vectors++;
      if (idx != int'(cnt)) begin
         miscompares++;
         $display("FAIL %s stream timeout: accepted %0d, required %0d", tag, idx, cnt);
      end
      // one cycle after last handshake: final write, no start yet
      vectors++;
      if (mem_we !== 1'b1 || fir_start !== 1'b0 || s_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s last_write: mem_we=%b fir_start=%b s_ready=%b, required 1/0/0", tag, mem_we, fir_start, s_ready);
      end
      @(negedge clk);
      vectors++;
      if (fir_start !== 1'b1 || mem_we !== 1'b0) begin
         miscompares++;
         $display("FAIL %s fir_start_latency: fir_start=%b mem_we=%b, required 1/0", tag, fir_start, mem_we);
      end
      @(negedge clk);
      // cfg_go while busy must be ignored and leave cfg_err alone
      cfg_go = 1'b1; cfg_count = 10'd0;
      @(negedge clk);
      cfg_go = 1'b0;
      vectors++;
      if (fir_start !== 1'b0 || busy !== 1'b1 || cfg_err !== 1'b0 || job_done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s wait_fir: fir_start=%b busy=%b cfg_err=%b job_done=%b, required 0/1/0/0", tag, fir_start, busy, cfg_err, job_done);
      end
      fir_done = 1'b1;
      @(negedge clk);
      fir_done = 1'b0;
      vectors++;
      if (job_done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s job_done_latency: job_done=%b, required 1", tag, job_done);
      end
      @(negedge clk);
      vectors++;
      if (job_done !== 1'b0 || busy !== 1'b0 || loaded_count !== cnt) begin
         miscompares++;
         $display("FAIL %s finish: job_done=%b busy=%b loaded_count=%0d, required 0/0/%0d", tag, job_done, busy, loaded_count, cnt);
      end
      vectors++;
      if (nwr != int'(cnt) || fs_cnt != 1 || overlap != 0) begin
         miscompares++;
         $display("FAIL %s counts: writes=%0d starts=%0d overlap=%0d, required %0d/1/0", tag, nwr, fs_cnt, overlap, cnt);
      end
      for (int i = 0; i < int'(cnt) && i < nwr && i < 64; i++) begin
         exp_addr = base + 10'(i);
         vectors++;
         if (wr_addr[i] !== exp_addr || wr_data[i] !== pat[i]) begin
            miscompares++;
            $display("FAIL %s write[%0d]: addr=%0d data=%02h, required addr=%0d data=%02h", tag, i, wr_addr[i], wr_data[i], exp_addr, pat[i]);
         end
         if (!toggle && i > 0) begin
            vectors++;
            if (wr_cyc[i] != wr_cyc[0] + i) begin
               miscompares++;
               $display("FAIL %s consecutive[%0d]: cycle=%0d, required %0d", tag, i, wr_cyc[i], wr_cyc[0] + i);
            end
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      vectors++;
      if (s_ready !== 1'b0 || mem_we !== 1'b0 || fir_start !== 1'b0 || busy !== 1'b0 ||
          job_done !== 1'b0 || cfg_err !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 8'd0 ||
          loaded_count !== 10'd0) begin
         miscompares++;
         $display("FAIL %s: rdy=%b we=%b start=%b busy=%b done=%b err=%b addr=%0d wdata=%02h cnt=%0d, required all zero",
                  tag, s_ready, mem_we, fir_start, busy, job_done, cfg_err, mem_addr, mem_wdata, loaded_count);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("post_reset_idle");
   endtask

   task automatic fill_step;
      for (int i = 0; i < 20; i++)
         pat[i] = (i < 5) ? 8'd64 : (i < 10) ? 8'd0 : (i < 15) ? 8'd32 : 8'd0;
   endtask

   task automatic test_step_stream;
      fill_step();
      run_job(10'd0, 10'd20, 1'b0, "step");
   endtask

   task automatic test_stalled_stream;
      fill_step();
      run_job(10'd0, 10'd20, 1'b1, "stall");
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 8; i++) pat[i] = 8'hA0 + 8'(i);
      run_job(10'd1020, 10'd8, 1'b0, "wrap");
      vectors++;
      if (wr_addr[3] !== 10'd1023 || wr_addr[4] !== 10'd0 || wr_addr[7] !== 10'd3) begin
         miscompares++;
         $display("FAIL wrap_edge: addr3=%0d addr4=%0d addr7=%0d, required 1023/0/3", wr_addr[3], wr_addr[4], wr_addr[7]);
      end
   endtask

   task automatic test_cfg_err;
      @(negedge clk);
      cfg_go = 1'b1; cfg_base_addr = 10'd0; cfg_count = 10'd0;
      @(negedge clk);
      cfg_go = 1'b0;
      vectors++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL cfg_err_zero: cfg_err=%b busy=%b s_ready=%b, required 1/0/0", cfg_err, busy, s_ready);
      end
      @(negedge clk);
      cfg_go = 1'b1; cfg_count = 10'd600;
      @(negedge clk);
      cfg_go = 1'b0;
      vectors++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL cfg_err_600: cfg_err=%b busy=%b, required 1/0", cfg_err, busy);
      end
      @(negedge clk);
      cfg_go = 1'b1; cfg_count = 10'd512;
      @(negedge clk);
      cfg_go = 1'b0;
      vectors++;
      if (cfg_err !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL cfg_max_legal: cfg_err=%b busy=%b, required 0/1", cfg_err, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cfg_go = 1'b1; cfg_count = 10'd600;
      @(negedge clk);
      cfg_go = 1'b0;
      vectors++;
      if (cfg_err !== 1'b1) begin
         miscompares++;
         $display("FAIL cfg_err_reraise: cfg_err=%b, required 1", cfg_err);
      end
      for (int i = 0; i < 5; i++) pat[i] = 8'(i * 3 + 1);
      run_job(10'd50, 10'd5, 1'b0, "cfg_recover");
      vectors++;
      if (cfg_err !== 1'b0) begin
         miscompares++;
         $display("FAIL cfg_err_cleared: cfg_err=%b, required 0", cfg_err);
      end
   endtask

   task automatic test_midjob_reset;
      int got;
      for (int i = 0; i < 10; i++) pat[i] = 8'h10 + 8'(i);
      @(negedge clk);
      cfg_go = 1'b1; cfg_base_addr = 10'd100; cfg_count = 10'd10;
      @(negedge clk);
      cfg_go = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = pat[i];
         @(negedge clk);
      end
      s_valid = 1'b0;
      vectors++;
      if (loaded_count !== 10'd3 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midjob_progress: loaded_count=%0d busy=%b, required 3/1", loaded_count, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("midjob_reset");
      fir_done = 1'b1;
      @(negedge clk);
      fir_done = 1'b0;
      got = 0;
      repeat (3) begin
         if (job_done) got++;
         @(negedge clk);
      end
      vectors++;
      if (got != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_fir_done: job_done pulses=%0d busy=%b, required 0/0", got, busy);
      end
      run_job(10'd200, 10'd10, 1'b0, "after_reset");
   endtask

`ifdef FIR_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      pat[0] = 8'd127; pat[1] = 8'h80; pat[2] = 8'hFF; pat[3] = 8'd2;
      run_job(10'd300, 10'd4, 1'b0, "csum_mixed");
      vectors++;
      if (checksum !== 16'h0000) begin
         miscompares++;
         $display("FAIL checksum_mixed: checksum=%04h, required 0000", checksum);
      end
      for (int i = 0; i < 5; i++) pat[i] = 8'd64;
      run_job(10'd300, 10'd5, 1'b0, "csum_64");
      vectors++;
      if (checksum !== 16'h0140) begin
         miscompares++;
         $display("FAIL checksum_64x5: checksum=%04h, required 0140", checksum);
      end
   endtask
`endif

   initial begin
      vectors = 0; miscompares = 0;
      nwr = 0; cyc = 0; fs_cnt = 0; overlap = 0;
      rst = 1'b1; cfg_go = 1'b0; cfg_base_addr = '0; cfg_count = '0;
      s_valid = 1'b0; s_data = '0; fir_done = 1'b0;
      test_reset();
      test_step_stream();
      test_stalled_stream();
      test_wrap();
      test_cfg_err();
      test_midjob_reset();
`ifdef FIR_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
